// File: rtl/line_buffer_nrow.sv
// Sliding vertical window over a raster stream: presents ROWS vertically adjacent
// pixels per accepted column, using a ring of ROWS-1 single-line memories.
module line_buffer_nrow #(
    parameter int PIXEL_WIDTH = 16,
    parameter int H_PIXELS    = 320,
    parameter int V_LINES     = 240,
    parameter int ROWS        = 3,
    parameter int EDGE_MODE   = 0
) (
    input  logic                                clk_in,
    input  logic                                rst_n_in,
    input  logic [10:0]                         hcount_in,
    input  logic [9:0]                          vcount_in,
    input  logic [PIXEL_WIDTH-1:0]              pixel_data_in,
    input  logic                                data_valid_in,
    output logic [ROWS-1:0][PIXEL_WIDTH-1:0]    line_buffer_out,
    output logic [10:0]                         hcount_out,
    output logic [9:0]                          vcount_out,
    output logic                                data_valid_out,
    output logic                                lines_ready_out
);

    localparam int NMEM = ROWS - 1;
    localparam int SW   = (NMEM > 1) ? $clog2(NMEM) : 1;
    localparam int AW   = (H_PIXELS > 1) ? $clog2(H_PIXELS) : 1;
    localparam int RW   = $clog2(ROWS);
    localparam int CTR  = (ROWS - 1) / 2;
    localparam logic [2:0] FILL_MAX = 3'(ROWS - 1);

    logic [SW-1:0] wr_sel, sel_next;
    logic [2:0]    fill_count, fill_next;
    logic          started;
    logic          accept, line_start, frame_start;
    logic [AW-1:0] addr;
    logic [9:0]    vc_shift;

    // The first line start after reset opens a frame whatever its vcount,
    // so the ring never advances over lines that were never written.
    always_comb begin
        accept      = data_valid_in && (hcount_in < 11'(H_PIXELS));
        line_start  = accept && (hcount_in == '0);
        frame_start = line_start && ((vcount_in == '0) || !started);
        addr        = hcount_in[AW-1:0];
        sel_next    = wr_sel;
        fill_next   = fill_count;
        if (frame_start) begin
            fill_next = '0;
        end else if (line_start) begin
            sel_next = (wr_sel == SW'(NMEM - 1)) ? '0 : wr_sel + SW'(1);
            if (fill_count != FILL_MAX) begin
                fill_next = fill_count + 3'd1;
            end
        end
        vc_shift = (vcount_in >= 10'(CTR)) ? vcount_in - 10'(CTR)
                                           : vcount_in + 10'(V_LINES - CTR);
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            wr_sel     <= '0;
            fill_count <= '0;
            started    <= 1'b0;
        end else if (accept) begin
            wr_sel     <= sel_next;
            fill_count <= fill_next;
            if (line_start) begin
                started <= 1'b1;
            end
        end
    end

    logic [PIXEL_WIDTH-1:0] rd_all [NMEM];

    for (genvar m = 0; m < NMEM; m++) begin : g_mem
        logic [PIXEL_WIDTH-1:0] mem [H_PIXELS];
        logic [PIXEL_WIDTH-1:0] rd;

        // Read-first: rd carries the content from before this cycle's write.
        always_ff @(posedge clk_in) begin
            if (accept) begin
                rd <= mem[addr];
                if (sel_next == SW'(m)) begin
                    mem[addr] <= pixel_data_in;
                end
            end
        end

        assign rd_all[m] = rd;
    end

    logic                   s1_valid;
    logic [PIXEL_WIDTH-1:0] s1_pix;
    logic [10:0]            s1_h;
    logic [9:0]             s1_v;
    logic [2:0]             s1_fill;
    logic [SW-1:0]          s1_sel;

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= accept;
        end
    end

    always_ff @(posedge clk_in) begin
        if (accept) begin
            s1_pix  <= pixel_data_in;
            s1_h    <= hcount_in;
            s1_v    <= vc_shift;
            s1_fill <= fill_next;
            s1_sel  <= sel_next;
        end
    end

    logic [PIXEL_WIDTH-1:0]              row_raw [ROWS];
    logic [ROWS-1:0][PIXEL_WIDTH-1:0]    row_out;
    logic [PIXEL_WIDTH-1:0]              edge_pix;

    assign row_raw[0] = s1_pix;
    assign row_out[0] = s1_pix;
    assign edge_pix   = row_raw[RW'(s1_fill)];

    // Row k comes from the memory written k lines ago; row ROWS-1 is the
    // memory being overwritten now, seen through its read-first port.
    for (genvar k = 1; k < ROWS; k++) begin : g_row
        logic [SW:0]   sum;
        logic [SW-1:0] idx;

        assign sum = {1'b0, s1_sel} + (SW+1)'(NMEM - k);
        assign idx = (sum >= (SW+1)'(NMEM)) ? SW'(sum - (SW+1)'(NMEM)) : SW'(sum);
        assign row_raw[k] = rd_all[idx];
        assign row_out[k] = (3'(k) <= s1_fill) ? row_raw[k] :
                            (EDGE_MODE != 0)   ? edge_pix   : '0;
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            line_buffer_out <= '0;
            hcount_out      <= '0;
            vcount_out      <= '0;
            data_valid_out  <= 1'b0;
            lines_ready_out <= 1'b0;
        end else if (s1_valid) begin
            line_buffer_out <= row_out;
            hcount_out      <= s1_h;
            vcount_out      <= s1_v;
            data_valid_out  <= 1'b1;
            lines_ready_out <= (s1_fill == FILL_MAX);
        end else begin
            data_valid_out  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_line_buffer_nrow.sv
// Scoreboard bench: three line buffer configurations (ROWS=3 zero fill, ROWS=3
// replicate, ROWS=5 zero fill) share one pixel stream; expectations come from line history.
module tb_line_buffer_nrow;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [10:0] hc;
    logic [9:0]  vc;
    logic [15:0] pix;
    logic        dvin;

    logic [2:0][15:0] lb_a, lb_b;
    logic [4:0][15:0] lb_c;
    logic [10:0] h_a, h_b, h_c;
    logic [9:0]  v_a, v_b, v_c;
    logic        dv_a, dv_b, dv_c, rdy_a, rdy_b, rdy_c;
    logic [111:0] pa_a, pa_b, pa_c;

    assign pa_a = 112'(lb_a);
    assign pa_b = 112'(lb_b);
    assign pa_c = 112'(lb_c);

    line_buffer_nrow #(.PIXEL_WIDTH(16), .H_PIXELS(4), .V_LINES(3), .ROWS(3), .EDGE_MODE(0)) dut_a (
        .clk_in(clk), .rst_n_in(rst_n), .hcount_in(hc), .vcount_in(vc),
        .pixel_data_in(pix), .data_valid_in(dvin), .line_buffer_out(lb_a),
        .hcount_out(h_a), .vcount_out(v_a), .data_valid_out(dv_a), .lines_ready_out(rdy_a));

    line_buffer_nrow #(.PIXEL_WIDTH(16), .H_PIXELS(4), .V_LINES(3), .ROWS(3), .EDGE_MODE(1)) dut_b (
        .clk_in(clk), .rst_n_in(rst_n), .hcount_in(hc), .vcount_in(vc),
        .pixel_data_in(pix), .data_valid_in(dvin), .line_buffer_out(lb_b),
        .hcount_out(h_b), .vcount_out(v_b), .data_valid_out(dv_b), .lines_ready_out(rdy_b));

    line_buffer_nrow #(.PIXEL_WIDTH(16), .H_PIXELS(4), .V_LINES(8), .ROWS(5), .EDGE_MODE(0)) dut_c (
        .clk_in(clk), .rst_n_in(rst_n), .hcount_in(hc), .vcount_in(vc),
        .pixel_data_in(pix), .data_valid_in(dvin), .line_buffer_out(lb_c),
        .hcount_out(h_c), .vcount_out(v_c), .data_valid_out(dv_c), .lines_ready_out(rdy_c));

    typedef struct {
        logic [6:0][15:0] rows;
        logic [10:0]      h;
        logic [9:0]       v;
        logic             rdy;
        int               t;
    } exp_t;

    exp_t qa[$], qb[$], qc[$];
    exp_t last_e [3];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit mon_en = 0;

    int rows_p [3] = '{3, 3, 5};
    int vl_p   [3] = '{3, 3, 8};
    int edge_p [3] = '{0, 1, 0};
    int fill_m [3];
    bit started_m [3];
    int base_q [3][7];

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic clear_expect();
        exp_t z;
        z.rows = '0; z.h = '0; z.v = '0; z.rdy = 1'b0; z.t = 0;
        qa.delete(); qb.delete(); qc.delete();
        for (int i = 0; i < 3; i++) begin
            last_e[i]    = z;
            fill_m[i]    = 0;
            started_m[i] = 0;
        end
    endtask

    // Expected output for an accepted pixel, from the history of line base values.
    task automatic push(input int v, input int h, input int data);
        for (int id = 0; id < 3; id++) begin
            exp_t e;
            int r, c, f;
            r = rows_p[id];
            if (h == 0) begin
                if (v == 0 || !started_m[id]) fill_m[id] = 0;
                else if (fill_m[id] < r - 1) fill_m[id]++;
                started_m[id] = 1;
                for (int k = 6; k > 0; k--) base_q[id][k] = base_q[id][k-1];
                base_q[id][0] = data - h;
            end
            f = fill_m[id];
            e.rows = '0;
            e.rows[0] = 16'(data);
            for (int k = 1; k < r; k++) begin
                if (k <= f)              e.rows[k] = 16'(base_q[id][k] + h);
                else if (edge_p[id] != 0) e.rows[k] = e.rows[f];
                else                     e.rows[k] = '0;
            end
            c = (r - 1) / 2;
            e.h   = 11'(h);
            e.v   = (v >= c) ? 10'(v - c) : 10'(v + vl_p[id] - c);
            e.rdy = (f == r - 1);
            e.t   = cyc;
            case (id)
                0: qa.push_back(e);
                1: qb.push_back(e);
                default: qc.push_back(e);
            endcase
        end
    endtask

    task automatic mon(input int id, input logic dv, input logic [111:0] rows,
                       input logic [10:0] h, input logic [9:0] v, input logic rdy);
        exp_t e;
        bit got;
        got = 0;
        if (dv === 1'b1) begin
            case (id)
                0: if (qa.size() > 0) begin e = qa.pop_front(); got = 1; end
                1: if (qb.size() > 0) begin e = qb.pop_front(); got = 1; end
                default: if (qc.size() > 0) begin e = qc.pop_front(); got = 1; end
            endcase
            if (!got) begin
                checks++;
                failures++;
                $display("FAIL unexpected_valid dut%0d actual=1 required=0 cycle=%0d", id, cyc);
            end else begin
                chk($sformatf("rows_dut%0d_h%0d", id, e.h), 128'(rows), 128'(e.rows));
                chk($sformatf("hcount_dut%0d", id), 128'(h), 128'(e.h));
                chk($sformatf("vcount_dut%0d", id), 128'(v), 128'(e.v));
                chk($sformatf("ready_dut%0d", id), 128'(rdy), 128'(e.rdy));
                chk($sformatf("latency_dut%0d", id), 128'(cyc - e.t), 128'(2));
                last_e[id] = e;
            end
        end else begin
            chk($sformatf("hold_rows_dut%0d", id), 128'(rows), 128'(last_e[id].rows));
            chk($sformatf("hold_h_dut%0d", id), 128'(h), 128'(last_e[id].h));
            chk($sformatf("hold_v_dut%0d", id), 128'(v), 128'(last_e[id].v));
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (mon_en) begin
            mon(0, dv_a, pa_a, h_a, v_a, rdy_a);
            mon(1, dv_b, pa_b, h_b, v_b, rdy_b);
            mon(2, dv_c, pa_c, h_c, v_c, rdy_c);
        end
    end

    task automatic chk_zero(input string tag);
        chk({tag, "_rows_a"}, 128'(pa_a), 128'(0));
        chk({tag, "_rows_b"}, 128'(pa_b), 128'(0));
        chk({tag, "_rows_c"}, 128'(pa_c), 128'(0));
        chk({tag, "_ctl_a"}, 128'({h_a, v_a, dv_a, rdy_a}), 128'(0));
        chk({tag, "_ctl_b"}, 128'({h_b, v_b, dv_b, rdy_b}), 128'(0));
        chk({tag, "_ctl_c"}, 128'({h_c, v_c, dv_c, rdy_c}), 128'(0));
    endtask

    task automatic drive(input int v, input int h, input int data, input logic valid);
        @(negedge clk);
        vc   = 10'(v);
        hc   = 11'(h);
        pix  = 16'(data);
        dvin = valid;
        if (valid && h < 4) push(v, h, data);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            dvin = 1'b0;
        end
    endtask

    task automatic send_line(input int fr, input int v);
        for (int h = 0; h < 4; h++) drive(v, h, 128*fr + 16*v + h, 1'b1);
        idle(1);
    endtask

    initial begin
        rst_n = 1'b0; dvin = 1'b0; hc = '0; vc = '0; pix = '0;
        clear_expect();
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst_n  = 1'b1;
        mon_en = 1;

        // frame 0, with an out-of-range column slipped into line 1
        send_line(0, 0);
        drive(1, 0, 16, 1'b1);
        drive(1, 1, 17, 1'b1);
        drive(1, 4, 16'hBEEF, 1'b1);
        drive(1, 2, 18, 1'b1);
        drive(1, 3, 19, 1'b1);
        idle(1);
        send_line(0, 2);

        // frame 1, interrupted by a one-cycle reset in line 2
        send_line(1, 0);
        send_line(1, 1);
        drive(2, 0, 128 + 32, 1'b1);
        drive(2, 1, 128 + 33, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        dvin  = 1'b0;
        clear_expect();
        @(negedge clk);
        chk_zero("midreset");
        rst_n = 1'b1;

        // lone pixel opening a line at vcount 2 right after reset
        drive(2, 0, 256 + 32, 1'b1);
        idle(4);

        // six lines in one frame wrap the ROWS=5 ring
        for (int v = 0; v < 6; v++) send_line(3, v);

        idle(6);
        chk("leftover_a", 128'(qa.size()), 128'(0));
        chk("leftover_b", 128'(qb.size()), 128'(0));
        chk("leftover_c", 128'(qc.size()), 128'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
